pipe_hazard_ctrl: RTL

Central hazard and stall controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It decodes load-use hazards and taken branches, and freezes the whole pipeline while the data-memory port withholds `mem_ack`. A wait watchdog drives a sticky error/halt state. It produces every pipeline-register enable and flush, including those for the ID→EX register, and keeps stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline.
// Decodes load-use, taken branch and memory freeze; watchdog halts on a stuck memory port.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        pc_sel_branch,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;
    logic        mem_err_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    logic        stall_mem;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        load_use;
    logic        br_sel;

    assign stall_mem = mem_req & ~mem_ack;
    assign rs1_hit   = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use  = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    // Conditions overlap, so order matters: freeze beats branch beats load-use.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        br_sel        = 1'b0;
        if (!res && state_q != ST_HALT) begin
            priority case (1'b1)
                stall_mem: begin
                end
                ex_branch_taken: begin
                    pc_en         = 1'b1;
                    if_id_en      = 1'b1;
                    id_ex_en      = 1'b1;
                    ex_mem_en     = 1'b1;
                    mem_wb_en     = 1'b1;
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    br_sel        = 1'b1;
                end
                load_use: begin
                    id_ex_en      = 1'b1;
                    ex_mem_en     = 1'b1;
                    mem_wb_en     = 1'b1;
                    id_ex_flush   = 1'b1;
                end
                default: begin
                    pc_en         = 1'b1;
                    if_id_en      = 1'b1;
                    id_ex_en      = 1'b1;
                    ex_mem_en     = 1'b1;
                    mem_wb_en     = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (stall_mem) begin
                    state_d = ST_WAIT;
                    wait_d  = 8'd1;
                end
            end
            ST_WAIT: begin
                if (!stall_mem) begin
                    state_d = ST_RUN;
                    wait_d  = 8'd0;
                end else if (wait_q < TO_LAST) begin
                    wait_d  = wait_q + 8'd1;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= ST_RUN;
            wait_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_q | (state_d == ST_HALT);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else if (state_q != ST_HALT) begin
            if (!pc_en) begin
                stall_q <= stall_q + 32'd1;
            end
            if (br_sel) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
